// File: rtl/hs_perf_monitor_if.sv
// Handshake and read-port bundle for hs_perf_monitor.
// The master side is the stimulus or owner; the slave side is the monitor.
interface hs_perf_monitor_if #(
    parameter int NUM_CH = 2,
    parameter int CNT_W  = 32
);
    logic [NUM_CH-1:0] ap_start;
    logic [NUM_CH-1:0] ap_ready;
    logic [NUM_CH-1:0] ap_done;
    logic [NUM_CH-1:0] ap_continue;
    logic [NUM_CH-1:0] iter_valid;
    logic [NUM_CH-1:0] iter_block;
    logic [NUM_CH-1:0] clear;
    logic              rd_en;
    logic [3:0]        rd_ch;
    logic [2:0]        rd_field;
    logic [CNT_W-1:0]  rd_data;
    logic              rd_valid;
    logic [NUM_CH-1:0] busy;
    logic [NUM_CH-1:0] ovf;

    modport master (
        output ap_start, ap_ready, ap_done, ap_continue, iter_valid, iter_block,
               clear, rd_en, rd_ch, rd_field,
        input  rd_data, rd_valid, busy, ovf
    );

    modport slave (
        input  ap_start, ap_ready, ap_done, ap_continue, iter_valid, iter_block,
               clear, rd_en, rd_ch, rd_field,
        output rd_data, rd_valid, busy, ovf
    );
endinterface

// File: rtl/hs_perf_monitor.sv
// Per-channel ap_ctrl performance monitor: latency, occupancy, stall and iteration
// statistics, with a registered read port.
module hs_perf_monitor_ch #(
    parameter int CNT_W = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  i_start,
    input  logic                  i_ready,
    input  logic                  i_done,
    input  logic                  i_cont,
    input  logic                  i_iter_valid,
    input  logic                  i_iter_block,
    input  logic                  i_clear,
    output logic                  o_busy,
    output logic                  o_ovf,
    output logic [7:0][CNT_W-1:0] o_fields
);
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_WAIT = 2'd2} state_t;
    localparam logic [CNT_W-1:0] MAXV = '1;

    state_t           r_state, w_next;
    logic             w_start, w_done, w_busy_inc, w_ovf_set;
    logic [CNT_W-1:0] w_lat;
    logic [CNT_W-1:0] r_lat, r_count, r_last, r_min, r_max, r_busy_cyc, r_stall, r_iter;
    logic             r_ovf, r_err;

    function automatic logic [CNT_W-1:0] f_sat(input logic [CNT_W-1:0] v);
        return (v == MAXV) ? v : v + CNT_W'(1);
    endfunction

    always_comb begin
        w_next  = r_state;
        w_start = 1'b0;
        w_done  = 1'b0;
        case (r_state)
            S_IDLE: if (i_start) begin
                w_next  = S_BUSY;
                w_start = 1'b1;
            end
            S_BUSY: if (i_done) begin
                w_done = 1'b1;
                if (!i_cont)      w_next  = S_WAIT;
                else if (i_start) w_start = 1'b1;
                else              w_next  = S_IDLE;
            end
            S_WAIT: if (i_cont) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // r_lat holds cycles elapsed since the start cycle; the done cycle adds one more.
    assign w_lat      = f_sat(r_lat);
    assign w_busy_inc = (r_state != S_IDLE) || w_start;
    assign w_ovf_set  = (w_busy_inc && r_busy_cyc == MAXV)
                     || (r_state == S_BUSY && i_iter_block && r_stall == MAXV)
                     || (r_state == S_BUSY && i_iter_valid && r_iter == MAXV)
                     || (w_done && (r_count == MAXV || r_lat == MAXV))
                     || (r_state == S_BUSY && !i_done && r_lat == MAXV);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)                            r_lat <= '0;
        else if (w_start)                      r_lat <= CNT_W'(1);
        else if (r_state == S_BUSY && !i_done) r_lat <= f_sat(r_lat);
    end

    // Clear wins over every update in the same cycle, including a done.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset || i_clear) begin
            r_count    <= '0;
            r_last     <= '0;
            r_min      <= MAXV;
            r_max      <= '0;
            r_busy_cyc <= '0;
            r_stall    <= '0;
            r_iter     <= '0;
            r_ovf      <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            if (w_busy_inc)                        r_busy_cyc <= f_sat(r_busy_cyc);
            if (r_state == S_BUSY && i_iter_block) r_stall    <= f_sat(r_stall);
            if (r_state == S_BUSY && i_iter_valid) r_iter     <= f_sat(r_iter);
            if (w_done) begin
                r_count <= f_sat(r_count);
                r_last  <= w_lat;
                if (w_lat < r_min) r_min <= w_lat;
                if (w_lat > r_max) r_max <= w_lat;
            end
            if (w_ovf_set)                    r_ovf <= 1'b1;
            if (r_state == S_IDLE && i_ready) r_err <= 1'b1;
        end
    end

    assign o_busy      = (r_state != S_IDLE);
    assign o_ovf       = r_ovf;
    assign o_fields[0] = r_count;
    assign o_fields[1] = r_last;
    assign o_fields[2] = r_min;
    assign o_fields[3] = r_max;
    assign o_fields[4] = r_busy_cyc;
    assign o_fields[5] = r_stall;
    assign o_fields[6] = r_iter;
    assign o_fields[7] = {{(CNT_W-4){1'b0}}, r_err, r_ovf, r_state};
endmodule

module hs_perf_monitor #(
    parameter int NUM_CH = 2,
    parameter int CNT_W  = 32
) (
    input logic              clock,
    input logic              reset,
    hs_perf_monitor_if.slave bus
);
    logic [NUM_CH-1:0][7:0][CNT_W-1:0] w_fields;
    logic [NUM_CH-1:0]                 w_busy, w_ovf;
    logic [CNT_W-1:0]                  w_rd_mux;
    logic [CNT_W-1:0]                  r_rd_data;
    logic                              r_rd_valid;

    genvar g;
    generate
        for (g = 0; g < NUM_CH; g++) begin : g_ch
            hs_perf_monitor_ch #(.CNT_W(CNT_W)) u_ch (
                .clock        (clock),
                .reset        (reset),
                .i_start      (bus.ap_start[g]),
                .i_ready      (bus.ap_ready[g]),
                .i_done       (bus.ap_done[g]),
                .i_cont       (bus.ap_continue[g]),
                .i_iter_valid (bus.iter_valid[g]),
                .i_iter_block (bus.iter_block[g]),
                .i_clear      (bus.clear[g]),
                .o_busy       (w_busy[g]),
                .o_ovf        (w_ovf[g]),
                .o_fields     (w_fields[g])
            );
        end
    endgenerate

    // Unmatched channel numbers fall through to zero.
    always_comb begin
        w_rd_mux = '0;
        for (int i = 0; i < NUM_CH; i++)
            if (bus.rd_ch == 4'(i)) w_rd_mux = w_fields[i][bus.rd_field];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_data  <= bus.rd_en ? w_rd_mux : '0;
            r_rd_valid <= bus.rd_en;
        end
    end

    assign bus.rd_data  = r_rd_data;
    assign bus.rd_valid = r_rd_valid;
    assign bus.busy     = w_busy;
    assign bus.ovf      = w_ovf;
endmodule

// File: doc/hs_perf_monitor.md
HS_PERF_MONITOR -- requirements
Module: hs_perf_monitor

Interface
REQ-001 Parameter NUM_CH, default 2, number of monitored ap_ctrl channels (1..16).
REQ-002 Parameter CNT_W, default 32, width of every statistic counter (16..48).
REQ-003 clock  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (reset==0 resets).
REQ-005 ap_start  input  NUM_CH  per-channel start, bit i = channel i.
REQ-006 ap_ready  input  NUM_CH  per-channel ready (input accepted).
REQ-007 ap_done  input  NUM_CH  per-channel done.
REQ-008 ap_continue  input  NUM_CH  per-channel continue (tie 1 when unused).
REQ-009 iter_valid  input  NUM_CH  one pulse per completed loop iteration.
REQ-010 iter_block  input  NUM_CH  pipeline subdone-block (stall) indicator.
REQ-011 clear  input  NUM_CH  synchronous per-channel statistics clear pulse.
REQ-012 rd_en  input  1  read request.
REQ-013 rd_ch  input  4  channel select for read.
REQ-014 rd_field  input  3  field select: 0 count, 1 last_lat, 2 min_lat, 3 max_lat, 4 busy_cycles, 5 stall_cycles, 6 iter_count, 7 status.
REQ-015 rd_data  output  CNT_W  read data.
REQ-016 rd_valid  output  1  read data valid.
REQ-017 busy  output  NUM_CH  channel in BUSY or WAIT_CONT.
REQ-018 ovf  output  NUM_CH  sticky: any counter of channel saturated.

Function
REQ-019 Each channel SHALL run an independent FSM: IDLE, BUSY, WAIT_CONT.
REQ-020 IDLE->BUSY when ap_start=1; that cycle is the start cycle.
REQ-021 BUSY->IDLE when ap_done=1 and ap_continue=1 and ap_start=0; BUSY->BUSY (new transaction, start cycle) when ap_done=1, ap_continue=1, ap_start=1.
REQ-022 BUSY->WAIT_CONT when ap_done=1 and ap_continue=0; WAIT_CONT->IDLE when ap_continue=1.
REQ-023 Latency SHALL equal done-cycle index minus start-cycle index plus 1; on each done: count+=1, last_lat=latency, min_lat=min, max_lat=max.
REQ-024 busy_cycles SHALL increment every cycle the FSM is BUSY or WAIT_CONT.
REQ-025 stall_cycles SHALL increment every BUSY cycle with iter_block=1; iter_count SHALL increment on every iter_valid=1 in BUSY; both ignored in IDLE and WAIT_CONT.
REQ-026 ap_ready SHALL be sampled only for status; a cycle with ap_ready=1 in IDLE SHALL set status bit 3 (protocol error, sticky).
REQ-027 All counters SHALL saturate at 2^CNT_W-1 and set ovf[i]; latency counter saturation also sets ovf[i].
REQ-028 min_lat SHALL read all-ones until the first completed transaction; max_lat reads 0.
REQ-029 clear[i]=1 SHALL reset channel i statistics, ovf[i] and error bit in the next cycle; FSM state and in-flight latency counter are retained; a done in the clear cycle is discarded.
REQ-030 rd_en=1 SHALL produce rd_data and rd_valid=1 exactly one cycle later; rd_valid=0 otherwise.
REQ-031 rd_ch>=NUM_CH SHALL return rd_data=0 with rd_valid=1.
REQ-032 status field SHALL be {zeros, error, ovf, state[1:0]} with IDLE=0, BUSY=1, WAIT_CONT=2.
REQ-033 A read of the same channel in the cycle of an update SHALL return the pre-update value.

Reset
REQ-034 On reset==0 all FSMs SHALL enter IDLE, all counters, last_lat, max_lat, ovf, busy, rd_data, rd_valid SHALL be 0, min_lat all-ones, asynchronously.
REQ-035 Reset asserted mid-transaction SHALL abort it with no statistic recorded; first edge after release SHALL be a normal IDLE cycle.

Verification
REQ-036 ch0 start at cycle 10, done+continue at cycle 14 -> count=1, last_lat=min_lat=max_lat=5, busy_cycles=5.
REQ-037 ch1 done with continue=0 for 3 cycles -> status state=2 for 3 cycles, busy_cycles includes them, then IDLE.
REQ-038 ch0 back-to-back done+start same cycle, latencies 4 then 7 -> count=2, min=4, max=7, busy stays 1.
REQ-039 CNT_W=16, 70000-cycle transaction -> last_lat=0xFFFF, ovf[0]=1 until clear; clear -> ovf=0, min_lat=0xFFFF.
REQ-040 rd_ch=5 with NUM_CH=2 -> rd_data=0, rd_valid=1 one cycle after rd_en.
REQ-041 reset pulled low at cycle 3 of a BUSY transaction -> busy=0 immediately, count=0 after release.
